shift_match_sched: RTL and testbench

- Arbiter and sequencer for one shared iterative shift-then-compare datapath.
- The datapath computes (data << lsh) >> rsh and compares the result against a key.
- Two requesters compete for it. The block grants one request at a time, round-robin, steps the shifter one bit per cycle, then returns the shifted value and match flag through a valid/ready response port.

---
 rtl/shift_match_sched_if.sv | 46 ++++
 rtl/shift_match_sched.sv | 125 ++++++++++++
 tb/tb_shift_match_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_match_sched_if.sv
// Command and response bundle for shift_match_sched: two requester channels
// plus a single valid/ready result channel.
interface shift_match_sched_if #(
  parameter int W  = 8,
  parameter int SW = 3
);
  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_data;
  logic [SW-1:0] req0_lsh;
  logic [SW-1:0] req0_rsh;
  logic [W-1:0]  req0_key;

  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_data;
  logic [SW-1:0] req1_lsh;
  logic [SW-1:0] req1_rsh;
  logic [W-1:0]  req1_key;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_value;
  logic          rsp_match;

  // Requesters and result consumer.
  modport master (
    output req0_valid, req0_data, req0_lsh, req0_rsh, req0_key,
    input  req0_ready,
    output req1_valid, req1_data, req1_lsh, req1_rsh, req1_key,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_value, rsp_match,
    output rsp_ready
  );

  // The scheduler itself.
  modport slave (
    input  req0_valid, req0_data, req0_lsh, req0_rsh, req0_key,
    output req0_ready,
    input  req1_valid, req1_data, req1_lsh, req1_rsh, req1_key,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_value, rsp_match,
    input  rsp_ready
  );
endinterface

// File: rtl/shift_match_sched.sv
// Round-robin scheduler for one shared bit-serial shift-then-compare unit:
// computes (data << lsh) >> rsh in W bits and flags equality with key.
module shift_match_sched #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_match_sched_if.slave    bus,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, SHL, SHR, CMP, RESP} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          id_q, id_d;
  logic [W-1:0]  value_q, value_d;
  logic [W-1:0]  key_q, key_d;
  logic [SW-1:0] lsh_q, lsh_d;
  logic [SW-1:0] rsh_q, rsh_d;
  logic          match_q, match_d;

  // Arbitration: req1 wins when it is alone or when the pointer favours it.
  logic          gnt1;
  logic          accept;
  logic [W-1:0]  sel_data, sel_key;
  logic [SW-1:0] sel_lsh, sel_rsh;

  assign gnt1     = bus.req1_valid && (!bus.req0_valid || rr_q);
  assign accept   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign sel_data = gnt1 ? bus.req1_data : bus.req0_data;
  assign sel_key  = gnt1 ? bus.req1_key  : bus.req0_key;
  assign sel_lsh  = gnt1 ? bus.req1_lsh  : bus.req0_lsh;
  assign sel_rsh  = gnt1 ? bus.req1_rsh  : bus.req0_rsh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (sel_lsh != '0) ? SHL :
                                  (sel_rsh != '0) ? SHR : CMP;
      SHL:  if (lsh_q == SW'(1)) state_d = (rsh_q != '0) ? SHR : CMP;
      SHR:  if (rsh_q == SW'(1)) state_d = CMP;
      CMP:  state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by rst_n so nothing is acknowledged while reset is held.
  always_comb begin
    busy           = (state_q != IDLE);
    bus.req0_ready = rst_n && accept && !gnt1;
    bus.req1_ready = rst_n && accept &&  gnt1;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_id     = id_q;
    bus.rsp_value  = (state_q == RESP) ? value_q : '0;
    bus.rsp_match  = (state_q == RESP) ? match_q : 1'b0;
  end

  // Datapath next-state: operands are captured only on the accept cycle.
  always_comb begin
    rr_d    = rr_q;
    id_d    = id_q;
    value_d = value_q;
    key_d   = key_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: if (accept) begin
        value_d = sel_data;
        key_d   = sel_key;
        lsh_d   = sel_lsh;
        rsh_d   = sel_rsh;
        id_d    = gnt1;
        rr_d    = ~gnt1;
      end
      SHL: begin
        value_d = {value_q[W-2:0], 1'b0};
        lsh_d   = lsh_q - SW'(1);
      end
      SHR: begin
        value_d = {1'b0, value_q[W-1:1]};
        rsh_d   = rsh_q - SW'(1);
      end
      CMP:  match_d = (value_q == key_q);
      RESP: if (bus.rsp_ready) begin
        value_d = '0;
        match_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      value_q <= '0;
      key_q   <= '0;
      lsh_q   <= '0;
      rsh_q   <= '0;
      match_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      id_q    <= id_d;
      value_q <= value_d;
      key_q   <= key_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      match_q <= match_d;
    end
  end

endmodule

// File: tb/tb_shift_match_sched.sv
// Directed bench for shift_match_sched: stimulus pushes hand-computed results
// into a scoreboard queue, an independent monitor checks each handshake.
module tb_shift_match_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  typedef struct {
    logic       id;
    logic [7:0] val;
    logic       match;
  } exp_t;

  exp_t sb_q[$];

  shift_match_sched_if #(.W(8), .SW(3)) bus ();

  shift_match_sched #(.W(8), .SW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_exp(input logic id, input logic [7:0] v, input logic m);
    exp_t e;
    e.id = id; e.val = v; e.match = m;
    sb_q.push_back(e);
  endfunction

  // Monitor: every response handshake is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_value), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id",    32'(bus.rsp_id),    32'(e.id));
          check("rsp_value", 32'(bus.rsp_value), 32'(e.val));
          check("rsp_match", 32'(bus.rsp_match), 32'(e.match));
        end
      end
    end
  end

  task automatic drive_req(input logic id, input logic [7:0] data, input logic [2:0] lsh,
                           input logic [2:0] rsh, input logic [7:0] key, input logic vld);
    if (id == 1'b0) begin
      bus.req0_data = data; bus.req0_lsh = lsh; bus.req0_rsh = rsh;
      bus.req0_key = key;   bus.req0_valid = vld;
    end else begin
      bus.req1_data = data; bus.req1_lsh = lsh; bus.req1_rsh = rsh;
      bus.req1_key = key;   bus.req1_valid = vld;
    end
  endtask

  // Presents one command, waits for its acceptance, optionally measures
  // cycles from accept to first rsp_valid (exp_lat < 0 skips that).
  task automatic run_cmd(input logic id, input logic [7:0] data, input logic [2:0] lsh,
                         input logic [2:0] rsh, input logic [7:0] key,
                         input logic [7:0] exp_val, input logic exp_match,
                         input bit want_rsp, input int exp_lat);
    int  acc_cyc;
    int  n;
    bit  got;
    logic rdy;
    @(posedge clk); #1;
    drive_req(id, data, lsh, rsh, key, 1'b1);
    got = 0;
    for (n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      if (rdy) got = 1;
    end
    check("accept", 32'(got), 32'd1);
    if (!got) begin
      drive_req(id, 8'h00, 3'd0, 3'd0, 8'h00, 1'b0);
      return;
    end
    acc_cyc = cyc;
    check("busy_at_accept", 32'(busy), 32'd0);
    if (want_rsp) push_exp(id, exp_val, exp_match);
    @(posedge clk); #1;
    // Scrambled fields must have no effect once the command is in flight.
    drive_req(id, ~data, ~lsh, ~rsh, ~key, 1'b0);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (exp_lat >= 0) begin
      got = bus.rsp_valid;
      for (n = 0; n < 50 && !got; n++) begin
        @(negedge clk);
        got = bus.rsp_valid;
      end
      check("rsp_seen", 32'(got), 32'd1);
      check("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    end
  endtask

  initial begin
    int grants;
    int order[4];
    int budget;
    int exp_order[4] = '{0, 1, 0, 1};

    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 1'b1);
    drive_req(1'b1, 8'h00, 3'd0, 3'd0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.rsp_valid, bus.rsp_id, bus.rsp_value, bus.rsp_match,
               busy, bus.req0_ready, bus.req1_ready}), 32'd0);
    drive_req(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 1'b0);
    drive_req(1'b1, 8'h00, 3'd0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Basic match: (0x03<<2)>>2 = 0x03.
    run_cmd(1'b0, 8'h03, 3'd2, 3'd2, 8'h03, 8'h03, 1'b1, 1, 6);
    // Truncation: 0xC1<<1 = 0x82 in 8 bits, >>1 = 0x41.
    run_cmd(1'b1, 8'hC1, 3'd1, 3'd1, 8'hC1, 8'h41, 1'b0, 1, 4);
    // Zero shifts: result is the operand itself, busy for two cycles.
    run_cmd(1'b0, 8'h5A, 3'd0, 3'd0, 8'h5A, 8'h5A, 1'b1, 1, 2);
    check("zs_busy_resp", 32'(busy), 32'd1);
    @(negedge clk);
    check("zs_busy_done", 32'(busy), 32'd0);

    // Backpressure: 0x81>>1 = 0x40, held for five stalled cycles.
    bus.rsp_ready = 1'b0;
    run_cmd(1'b0, 8'h81, 3'd0, 3'd1, 8'h40, 8'h40, 1'b1, 1, 3);
    drive_req(1'b1, 8'h33, 3'd1, 3'd1, 8'h33, 1'b1);
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold",
            32'({bus.rsp_valid, bus.rsp_id, bus.rsp_value, bus.rsp_match,
                 bus.req0_ready, bus.req1_ready}),
            32'({1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0}));
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle", 32'({busy, bus.rsp_valid, bus.rsp_value}), 32'd0);

    // Reset during the third SHL cycle of a 7-bit left shift.
    run_cmd(1'b0, 8'hFF, 3'd7, 3'd0, 8'h80, 8'h00, 1'b0, 0, -1);
    repeat (2) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'd1);
    bus.req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          32'({bus.rsp_valid, bus.rsp_id, bus.rsp_value, bus.rsp_match,
               busy, bus.req0_ready, bus.req1_ready}), 32'd0);
    repeat (2) @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    // 0x01<<1 = 0x02 matches key 0x02.
    run_cmd(1'b1, 8'h01, 3'd1, 3'd0, 8'h02, 8'h02, 1'b1, 1, 3);

    // Round robin with both requesters continuously valid.
    @(posedge clk); #1;
    drive_req(1'b0, 8'h0F, 3'd1, 3'd0, 8'h1E, 1'b1);
    drive_req(1'b1, 8'h80, 3'd0, 3'd3, 8'h00, 1'b1);
    grants = 0;
    budget = 0;
    while (grants < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (bus.req0_ready) begin
        order[grants] = 0;
        push_exp(1'b0, 8'h1E, 1'b1);
        grants++;
      end else if (bus.req1_ready) begin
        order[grants] = 1;
        push_exp(1'b1, 8'h10, 1'b0);
        grants++;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_grants", 32'(grants), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end

    budget = 0;
    while (sb_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (20) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
